// File: rtl/mips32_5stage_cpu.sv
// Five-stage pipelined MIPS32 integer core (IF, ID, EX, MEM, WB) with EX operand forwarding,
// a load-use interlock, branches resolved in EX and jumps resolved in ID.
module mips32_5stage_cpu #(
    parameter int unsigned DMEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction_i,
    output logic [31:0] inst_mem_rd_addr_to_instmem
);

    localparam int unsigned AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2a;

    typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        alu_src_imm;
        alu_op_e     alu_op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [31:0] pc4;
    } idex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  dst;
        logic [31:0] alu_res;
        logic [31:0] store_data;
    } exmem_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic [4:0]  dst;
        logic [31:0] alu_res;
        logic [31:0] rdata;
    } memwb_t;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    idex_t       idex_q, idex_d, id_dec;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;

    logic [31:0] rf_q   [32];
    logic [31:0] dmem_q [DMEM_WORDS];

    logic [5:0]  id_op, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_imm, id_rs_val, id_rt_val, id_jump_target;
    logic        id_jump, ld_use_stall;

    logic [31:0] ex_a, ex_b, ex_opb, ex_res, br_target;
    logic        br_taken;

    logic [AW-1:0] dmem_idx;
    logic [31:0]   wb_data;

    assign inst_mem_rd_addr_to_instmem = pc_q;

    // ---------------- ID ----------------
    assign id_op          = ifid_instr_q[31:26];
    assign id_rs          = ifid_instr_q[25:21];
    assign id_rt          = ifid_instr_q[20:16];
    assign id_rd          = ifid_instr_q[15:11];
    assign id_funct       = ifid_instr_q[5:0];
    assign id_imm         = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};
    assign id_jump_target = {ifid_pc4_q[31:28], ifid_instr_q[25:0], 2'b00};

    assign wb_data = memwb_q.mem_read ? memwb_q.rdata : memwb_q.alu_res;

    // Register read with same-cycle bypass of the WB write.
    always_comb begin
        id_rs_val = rf_q[id_rs];
        if (id_rs == 5'd0) begin
            id_rs_val = '0;
        end else if (memwb_q.reg_write && memwb_q.dst == id_rs) begin
            id_rs_val = wb_data;
        end
        id_rt_val = rf_q[id_rt];
        if (id_rt == 5'd0) begin
            id_rt_val = '0;
        end else if (memwb_q.reg_write && memwb_q.dst == id_rt) begin
            id_rt_val = wb_data;
        end
    end

    always_comb begin
        id_dec        = '0;
        id_dec.rs     = id_rs;
        id_dec.rt     = id_rt;
        id_dec.rs_val = id_rs_val;
        id_dec.rt_val = id_rt_val;
        id_dec.imm    = id_imm;
        id_dec.pc4    = ifid_pc4_q;
        id_jump       = 1'b0;
        case (id_op)
            OpRtype: begin
                id_dec.dst       = id_rd;
                id_dec.reg_write = 1'b1;
                case (id_funct)
                    FnAdd:   id_dec.alu_op = AluAdd;
                    FnSub:   id_dec.alu_op = AluSub;
                    FnAnd:   id_dec.alu_op = AluAnd;
                    FnOr:    id_dec.alu_op = AluOr;
                    FnSlt:   id_dec.alu_op = AluSlt;
                    default: id_dec.reg_write = 1'b0;
                endcase
            end
            OpAddi: begin
                id_dec.dst         = id_rt;
                id_dec.reg_write   = 1'b1;
                id_dec.alu_src_imm = 1'b1;
            end
            OpLw: begin
                id_dec.dst         = id_rt;
                id_dec.reg_write   = 1'b1;
                id_dec.mem_read    = 1'b1;
                id_dec.alu_src_imm = 1'b1;
            end
            OpSw: begin
                id_dec.mem_write   = 1'b1;
                id_dec.alu_src_imm = 1'b1;
            end
            OpBeq:   id_dec.branch = 1'b1;
            OpJ:     id_jump = 1'b1;
            default: ;
        endcase
    end

    // Conservative: any reference to the load destination in ID's rs/rt fields interlocks.
    assign ld_use_stall = idex_q.mem_read && (idex_q.dst != 5'd0) &&
                          ((idex_q.dst == id_rs) || (idex_q.dst == id_rt));

    // ---------------- EX ----------------
    always_comb begin
        ex_a = idex_q.rs_val;
        if (exmem_q.reg_write && exmem_q.dst != 5'd0 && exmem_q.dst == idex_q.rs) begin
            ex_a = exmem_q.alu_res;
        end else if (memwb_q.reg_write && memwb_q.dst != 5'd0 && memwb_q.dst == idex_q.rs) begin
            ex_a = wb_data;
        end
        ex_b = idex_q.rt_val;
        if (exmem_q.reg_write && exmem_q.dst != 5'd0 && exmem_q.dst == idex_q.rt) begin
            ex_b = exmem_q.alu_res;
        end else if (memwb_q.reg_write && memwb_q.dst != 5'd0 && memwb_q.dst == idex_q.rt) begin
            ex_b = wb_data;
        end

        ex_opb = idex_q.alu_src_imm ? idex_q.imm : ex_b;
        case (idex_q.alu_op)
            AluSub:  ex_res = ex_a - ex_opb;
            AluAnd:  ex_res = ex_a & ex_opb;
            AluOr:   ex_res = ex_a | ex_opb;
            AluSlt:  ex_res = {31'b0, $signed(ex_a) < $signed(ex_opb)};
            default: ex_res = ex_a + ex_opb;
        endcase

        br_taken  = idex_q.branch && (ex_a == ex_b);
        br_target = idex_q.pc4 + {idex_q.imm[29:0], 2'b00};
    end

    // ---------------- MEM ----------------
    assign dmem_idx = exmem_q.alu_res[AW-1:0];

    // ---------------- next state ----------------
    always_comb begin
        pc_d         = pc_q + 32'd4;
        ifid_instr_d = instruction_i;
        ifid_pc4_d   = pc_q + 32'd4;
        idex_d       = id_dec;
        // Priority: EX branch over ID jump over load-use stall.
        if (br_taken) begin
            pc_d         = br_target;
            ifid_instr_d = '0;
            ifid_pc4_d   = '0;
            idex_d       = '0;
        end else if (id_jump) begin
            pc_d         = id_jump_target;
            ifid_instr_d = '0;
            ifid_pc4_d   = '0;
            idex_d       = '0;
        end else if (ld_use_stall) begin
            pc_d         = pc_q;
            ifid_instr_d = ifid_instr_q;
            ifid_pc4_d   = ifid_pc4_q;
            idex_d       = '0;
        end

        exmem_d.reg_write  = idex_q.reg_write;
        exmem_d.mem_read   = idex_q.mem_read;
        exmem_d.mem_write  = idex_q.mem_write;
        exmem_d.dst        = idex_q.dst;
        exmem_d.alu_res    = ex_res;
        exmem_d.store_data = ex_b;

        memwb_d.reg_write = exmem_q.reg_write;
        memwb_d.mem_read  = exmem_q.mem_read;
        memwb_d.dst       = exmem_q.dst;
        memwb_d.alu_res   = exmem_q.alu_res;
        memwb_d.rdata     = dmem_q[dmem_idx];
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc_q         <= '0;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            idex_q       <= '0;
            exmem_q      <= '0;
            memwb_q      <= '0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            idex_q       <= idex_d;
            exmem_q      <= exmem_d;
            memwb_q      <= memwb_d;
            if (memwb_q.reg_write && memwb_q.dst != 5'd0) begin
                rf_q[memwb_q.dst] <= wb_data;
            end
        end
    end

    // Data memory keeps its contents across reset; a store in MEM during reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n && exmem_q.mem_write) begin
            dmem_q[dmem_idx] <= exmem_q.store_data;
        end
    end

endmodule

// File: tb/tb_mips32_5stage_cpu.sv
// Scoreboard bench for mips32_5stage_cpu: expected PC trace and final register/memory
// state are queued when a program is set up and compared as the core produces them.
module tb_mips32_5stage_cpu;

    localparam int unsigned DmemWords = 32;

    localparam logic [5:0] OpJ    = 6'd2;
    localparam logic [5:0] OpBeq  = 6'd4;
    localparam logic [5:0] OpAddi = 6'd8;
    localparam logic [5:0] OpLw   = 6'd35;
    localparam logic [5:0] OpSw   = 6'd43;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnSlt  = 6'h2a;

    typedef struct packed {
        logic        is_mem;
        logic [4:0]  idx;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction_i;
    logic [31:0] pc;
    logic [31:0] imem [64];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [31:0] pc_exp_q [$];
    exp_t        state_exp_q [$];

    mips32_5stage_cpu #(
        .DMEM_WORDS(DmemWords)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .instruction_i              (instruction_i),
        .inst_mem_rd_addr_to_instmem(pc)
    );

    always #5 clk = ~clk;

    assign instruction_i = (pc < 32'd256) ? imem[pc[7:2]] : 32'h0;

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [5:0] funct);
        return {6'd0, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {OpJ, target};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_pc();
        logic [31:0] e;
        if (pc_exp_q.size() > 0) begin
            e = pc_exp_q.pop_front();
            check_eq($sformatf("pc@%0d", cyc), pc, e);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            check_pc();
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic expect_linear(input int n);
        for (int i = 0; i < n; i++) pc_exp_q.push_back(32'(4 * i));
    endtask

    task automatic exp_reg(input int r, input logic [31:0] v);
        state_exp_q.push_back('{is_mem: 1'b0, idx: 5'(r), val: v});
    endtask

    task automatic exp_mem(input int a, input logic [31:0] v);
        state_exp_q.push_back('{is_mem: 1'b1, idx: 5'(a), val: v});
    endtask

    task automatic check_state();
        exp_t        e;
        logic [31:0] got;
        while (state_exp_q.size() > 0) begin
            e   = state_exp_q.pop_front();
            got = e.is_mem ? dut.dmem_q[e.idx] : dut.rf_q[e.idx];
            check_eq($sformatf("%s[%0d]", e.is_mem ? "dmem" : "r", e.idx), got, e.val);
        end
    endtask

    // Leaves reset asserted; PC must read 0 at every sampled cycle.
    task automatic apply_reset(input int n);
        rst_n = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pc_exp_q.push_back(32'd0);
            check_pc();
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b0;
        cyc   = 0;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    initial begin
        rst_n = 1'b1;
        clear_imem();

        // Reset behaviour and free-running fetch.
        apply_reset(5);
        release_reset();
        expect_linear(4);
        run(4);
        for (int r = 0; r < 32; r++) exp_reg(r, 32'd0);
        check_state();

        // Loads, load-use interlock, forwarded store data.
        apply_reset(2);
        clear_imem();
        imem[0] = enc_i(OpLw, 5'd1, 5'd0, 16'd0);
        imem[1] = enc_i(OpLw, 5'd2, 5'd0, 16'd1);
        imem[2] = enc_r(5'd3, 5'd1, 5'd2, FnAdd);
        imem[3] = enc_i(OpSw, 5'd3, 5'd0, 16'd3);
        dut.dmem_q[0] = 32'd1;
        dut.dmem_q[1] = 32'd5;
        dut.dmem_q[3] = 32'hdeadbeef;
        release_reset();
        pc_exp_q.push_back(32'd0);
        pc_exp_q.push_back(32'd4);
        pc_exp_q.push_back(32'd8);
        pc_exp_q.push_back(32'd12);
        pc_exp_q.push_back(32'd12);
        pc_exp_q.push_back(32'd16);
        pc_exp_q.push_back(32'd20);
        run(14);
        exp_reg(1, 32'd1);
        exp_reg(2, 32'd5);
        exp_reg(3, 32'd6);
        exp_mem(3, 32'd6);
        exp_mem(1, 32'd5);
        check_state();

        // Back-to-back forwarding across ALU ops, $0 sink, unsupported funct.
        apply_reset(2);
        clear_imem();
        imem[0]  = enc_i(OpAddi, 5'd1, 5'd0, 16'd7);
        imem[1]  = enc_i(OpAddi, 5'd2, 5'd1, 16'd3);
        imem[2]  = enc_r(5'd3, 5'd2, 5'd1, FnSub);
        imem[3]  = enc_r(5'd4, 5'd1, 5'd2, FnSlt);
        imem[4]  = enc_i(OpAddi, 5'd0, 5'd0, 16'd9);
        imem[5]  = enc_r(5'd5, 5'd2, 5'd1, FnAnd);
        imem[6]  = enc_r(5'd6, 5'd2, 5'd1, FnOr);
        imem[7]  = enc_r(5'd7, 5'd2, 5'd1, FnSlt);
        imem[8]  = enc_r(5'd8, 5'd3, 5'd4, FnAdd);
        imem[9]  = enc_i(OpAddi, 5'd9, 5'd0, 16'hffff);
        imem[10] = enc_r(5'd10, 5'd9, 5'd1, FnSlt);
        imem[11] = enc_r(5'd11, 5'd1, 5'd2, FnAddu);
        imem[12] = enc_r(5'd12, 5'd0, 5'd1, FnSub);
        release_reset();
        expect_linear(14);
        run(20);
        exp_reg(0, 32'd0);
        exp_reg(1, 32'd7);
        exp_reg(2, 32'd10);
        exp_reg(3, 32'd3);
        exp_reg(4, 32'd1);
        exp_reg(5, 32'd2);
        exp_reg(6, 32'd15);
        exp_reg(7, 32'd0);
        exp_reg(8, 32'd4);
        exp_reg(9, 32'hffffffff);
        exp_reg(10, 32'd1);
        exp_reg(11, 32'd0);
        exp_reg(12, 32'hfffffff9);
        check_state();

        // Taken and not-taken beq; operand forwarded from EX/MEM.
        for (int pass = 0; pass < 2; pass++) begin
            apply_reset(2);
            clear_imem();
            imem[0] = enc_i(OpAddi, 5'd5, 5'd0, 16'd1);
            imem[1] = enc_i(OpBeq, (pass == 0) ? 5'd5 : 5'd0, 5'd5, 16'd2);
            imem[2] = enc_i(OpAddi, 5'd6, 5'd0, 16'd1);
            imem[3] = enc_i(OpAddi, 5'd7, 5'd0, 16'd1);
            imem[4] = enc_i(OpAddi, 5'd8, 5'd0, 16'd1);
            release_reset();
            expect_linear(7);
            run(12);
            exp_reg(5, 32'd1);
            exp_reg(6, (pass == 0) ? 32'd0 : 32'd1);
            exp_reg(7, (pass == 0) ? 32'd0 : 32'd1);
            exp_reg(8, 32'd1);
            check_state();
        end

        // Jump back to 0; the slot after j is flushed.
        apply_reset(2);
        clear_imem();
        imem[0] = enc_i(OpAddi, 5'd10, 5'd0, 16'd5);
        imem[3] = enc_j(26'd0);
        imem[4] = enc_i(OpAddi, 5'd9, 5'd9, 16'd1);
        release_reset();
        for (int k = 0; k < 2; k++) expect_linear(5);
        pc_exp_q.push_back(32'd0);
        run(16);
        exp_reg(9, 32'd0);
        exp_reg(10, 32'd5);
        check_state();

        // Reset while addi/sw/add are in flight: none may write afterwards.
        apply_reset(2);
        clear_imem();
        imem[0] = enc_i(OpAddi, 5'd1, 5'd0, 16'd7);
        imem[1] = enc_i(OpSw, 5'd1, 5'd0, 16'd2);
        imem[2] = enc_r(5'd3, 5'd1, 5'd1, FnAdd);
        dut.dmem_q[2] = 32'h55;
        release_reset();
        expect_linear(3);
        run(3);
        clear_imem();
        apply_reset(1);
        release_reset();
        expect_linear(8);
        run(8);
        for (int r = 0; r < 32; r++) exp_reg(r, 32'd0);
        exp_mem(2, 32'h55);
        check_state();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
